// File: rtl/bus_grant_encoder.sv
// Bus grant encoder: arbitrates N_SRC out-enable requests to one encoded
// select, with fixed-priority or round-robin policy, lock hold and a
// saturating collision counter.
//
// Ports:
//   clock     - rising-edge clock
//   clear     - asynchronous active-high reset
//   req       - per-source requests, bit i = source i
//   en        - arbitration enable
//   lock      - hold the current grant while one exists
//   clr_err   - synchronous clear of err_cnt (wins over increment)
//   sel       - registered index of granted source
//   sel_valid - registered, high while sel names an active grant
//   multi     - registered, last arbitrated cycle had >= 2 requests
//   err_cnt   - saturating count of collision cycles
module bus_grant_encoder #(
    parameter int N_SRC   = 24,
    parameter int SEL_W   = 5,
    parameter int RR_MODE = 0,
    parameter int CNT_W   = 8
) (
    input  logic             clock,
    input  logic             clear,
    input  logic [N_SRC-1:0] req,
    input  logic             en,
    input  logic             lock,
    input  logic             clr_err,
    output logic [SEL_W-1:0] sel,
    output logic             sel_valid,
    output logic             multi,
    output logic [CNT_W-1:0] err_cnt
);

    typedef enum logic {
        IDLE,
        GRANTED
    } state_t;

    localparam int REQ_X_W = 1 << SEL_W;

    state_t           state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic             multi_q, multi_d;
    logic [CNT_W-1:0] err_q, err_d;

    logic [REQ_X_W-1:0] req_x;
    logic [SEL_W:0]     base;
    logic [SEL_W:0]     sum;
    logic [SEL_W-1:0]   pick;
    logic               found;
    logic               collide;

    // Search start: the round-robin pointer, or 0 for fixed priority.
    // The request vector is zero-padded so any SEL_W-bit index is legal.
    always_comb begin
        req_x = '0;
        req_x[N_SRC-1:0] = req;
        base  = (RR_MODE != 0) ? {1'b0, ptr_q} : '0;
        sum   = '0;
        pick  = '0;
        found = 1'b0;
        for (int i = 0; i < N_SRC; i++) begin
            sum = base + (SEL_W+1)'(i);
            if (sum >= (SEL_W+1)'(N_SRC)) begin
                sum = sum - (SEL_W+1)'(N_SRC);
            end
            if (!found && req_x[sum[SEL_W-1:0]]) begin
                found = 1'b1;
                pick  = sum[SEL_W-1:0];
            end
        end
    end

    // Two or more bits set iff clearing the lowest set bit leaves some.
    assign collide = |(req & (req - N_SRC'(1)));

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        multi_d = multi_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (en) begin
                    multi_d = collide;
                    if (found) begin
                        state_d = GRANTED;
                        sel_d   = pick;
                    end
                end
            end
            GRANTED: begin
                if (en && lock) begin
                    multi_d = 1'b0;
                end else if (en) begin
                    multi_d = collide;
                    if (found) begin
                        sel_d = pick;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // Pointer and counter move only on true arbitration cycles.
        if (en && !(lock && state_q == GRANTED)) begin
            if (found) begin
                ptr_d = (pick == SEL_W'(N_SRC - 1)) ? '0 : pick + SEL_W'(1);
            end
            if (collide && err_q != '1) begin
                err_d = err_q + CNT_W'(1);
            end
        end
        if (clr_err) begin
            err_d = '0;
        end
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q <= IDLE;
            sel_q   <= '0;
            ptr_q   <= '0;
            multi_q <= 1'b0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            multi_q <= multi_d;
            err_q   <= err_d;
        end
    end

    assign sel       = sel_q;
    assign sel_valid = (state_q == GRANTED);
    assign multi     = multi_q;
    assign err_cnt   = err_q;

endmodule

// File: tb/tb_bus_grant_encoder.sv
// Directed bench for bus_grant_encoder: fixed-priority, round-robin and
// small-counter instances driven from shared inputs.
module tb_bus_grant_encoder;

    logic        clock = 1'b0;
    logic        clear = 1'b0;
    logic [23:0] req = '0;
    logic        en = 1'b0;
    logic        lock = 1'b0;
    logic        clr_err = 1'b0;

    logic [4:0] f_sel, r_sel, s_sel;
    logic       f_v, r_v, s_v;
    logic       f_m, r_m, s_m;
    logic [7:0] f_e, r_e;
    logic [1:0] s_e;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    bus_grant_encoder #(.RR_MODE(0)) u_fix (
        .clock(clock), .clear(clear), .req(req), .en(en),
        .lock(lock), .clr_err(clr_err), .sel(f_sel),
        .sel_valid(f_v), .multi(f_m), .err_cnt(f_e)
    );

    bus_grant_encoder #(.RR_MODE(1)) u_rr (
        .clock(clock), .clear(clear), .req(req), .en(en),
        .lock(lock), .clr_err(clr_err), .sel(r_sel),
        .sel_valid(r_v), .multi(r_m), .err_cnt(r_e)
    );

    bus_grant_encoder #(.CNT_W(2)) u_sat (
        .clock(clock), .clear(clear), .req(req), .en(en),
        .lock(lock), .clr_err(clr_err), .sel(s_sel),
        .sel_valid(s_v), .multi(s_m), .err_cnt(s_e)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        #2;
        clear = 1'b0;
    endtask

    task automatic test_reset();
        clear = 1'b1;
        en = 1'b1;
        req = 24'hFF;
        #1;
        n_cmp++;
        if ({f_sel, f_v, f_m, f_e} !== 15'h0) begin
            n_bad++;
            $display("FAIL reset_fix got %h want 0", {f_sel, f_v, f_m, f_e});
        end
        tick();
        n_cmp++;
        if ({r_sel, r_v, r_m, r_e} !== 15'h0) begin
            n_bad++;
            $display("FAIL reset_held_rr got %h want 0", {r_sel, r_v, r_m, r_e});
        end
        clear = 1'b0;
        req = '0;
        en = 1'b0;
    endtask

    task automatic test_fixed();
        pulse_clear();
        en = 1'b1;
        req = 24'h000024;
        tick();
        n_cmp++;
        if ({f_sel, f_v, f_m, f_e} !== {5'd2, 1'b1, 1'b1, 8'd1}) begin
            n_bad++;
            $display("FAIL fix_collide got %h want %h",
                     {f_sel, f_v, f_m, f_e}, {5'd2, 1'b1, 1'b1, 8'd1});
        end
        req = 24'h000100;
        tick();
        n_cmp++;
        if ({f_sel, f_v, f_m, f_e} !== {5'd8, 1'b1, 1'b0, 8'd1}) begin
            n_bad++;
            $display("FAIL fix_single got %h want %h",
                     {f_sel, f_v, f_m, f_e}, {5'd8, 1'b1, 1'b0, 8'd1});
        end
        req = 24'h800000;
        tick();
        n_cmp++;
        if ({f_sel, f_v, f_m} !== {5'd23, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL fix_top got %h want %h",
                     {f_sel, f_v, f_m}, {5'd23, 1'b1, 1'b0});
        end
        req = '0;
        tick();
        n_cmp++;
        if ({f_sel, f_v, f_m, f_e} !== {5'd23, 1'b0, 1'b0, 8'd1}) begin
            n_bad++;
            $display("FAIL fix_noreq got %h want %h",
                     {f_sel, f_v, f_m, f_e}, {5'd23, 1'b0, 1'b0, 8'd1});
        end
        en = 1'b0;
    endtask

    task automatic test_round_robin();
        logic [4:0] exp_sel [3];
        exp_sel[0] = 5'd0;
        exp_sel[1] = 5'd23;
        exp_sel[2] = 5'd0;
        pulse_clear();
        en = 1'b1;
        req = 24'h800001;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if ({r_sel, r_v, r_m} !== {exp_sel[i], 1'b1, 1'b1}) begin
                n_bad++;
                $display("FAIL rr_step%0d got %h want %h", i,
                         {r_sel, r_v, r_m}, {exp_sel[i], 1'b1, 1'b1});
            end
        end
        n_cmp++;
        if (r_e !== 8'd3) begin
            n_bad++;
            $display("FAIL rr_errcnt got %0d want 3", r_e);
        end
        n_cmp++;
        if (f_sel !== 5'd0) begin
            n_bad++;
            $display("FAIL fix_no_rotate got %0d want 0", f_sel);
        end
        req = '0;
        en = 1'b0;
    endtask

    task automatic test_lock();
        pulse_clear();
        en = 1'b1;
        req = 24'h000080;
        tick();
        n_cmp++;
        if ({f_sel, f_v} !== {5'd7, 1'b1}) begin
            n_bad++;
            $display("FAIL lock_grant got %h want %h", {f_sel, f_v}, {5'd7, 1'b1});
        end
        lock = 1'b1;
        for (int i = 0; i < 5; i++) begin
            req = (i == 4) ? 24'h000003 : 24'h000001;
            tick();
            n_cmp++;
            if ({f_sel, f_v, f_m, f_e} !== {5'd7, 1'b1, 1'b0, 8'd0}) begin
                n_bad++;
                $display("FAIL lock_hold%0d got %h want %h", i,
                         {f_sel, f_v, f_m, f_e}, {5'd7, 1'b1, 1'b0, 8'd0});
            end
        end
        lock = 1'b0;
        req = 24'h000001;
        tick();
        n_cmp++;
        if ({f_sel, f_v, f_m} !== {5'd0, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL lock_release got %h want %h",
                     {f_sel, f_v, f_m}, {5'd0, 1'b1, 1'b0});
        end
        en = 1'b0;
        req = 24'h000030;
        tick();
        n_cmp++;
        if ({f_sel, f_v, f_m, f_e} !== {5'd0, 1'b1, 1'b0, 8'd0}) begin
            n_bad++;
            $display("FAIL en_off_hold got %h want %h",
                     {f_sel, f_v, f_m, f_e}, {5'd0, 1'b1, 1'b0, 8'd0});
        end
        req = '0;
    endtask

    task automatic test_saturate();
        logic [1:0] exp_e [5];
        exp_e[0] = 2'd1;
        exp_e[1] = 2'd2;
        exp_e[2] = 2'd3;
        exp_e[3] = 2'd3;
        exp_e[4] = 2'd3;
        pulse_clear();
        en = 1'b1;
        req = 24'h000003;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++;
            if ({s_e, s_m} !== {exp_e[i], 1'b1}) begin
                n_bad++;
                $display("FAIL sat_step%0d got %h want %h", i,
                         {s_e, s_m}, {exp_e[i], 1'b1});
            end
        end
        n_cmp++;
        if (f_e !== 8'd5) begin
            n_bad++;
            $display("FAIL wide_cnt got %0d want 5", f_e);
        end
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        n_cmp++;
        if ({s_e, f_e} !== 10'd0) begin
            n_bad++;
            $display("FAIL clr_err_wins got %h want 0", {s_e, f_e});
        end
        req = '0;
        en = 1'b0;
    endtask

    task automatic test_idle_clear();
        pulse_clear();
        en = 1'b1;
        req = 24'h000030;
        tick();
        req = '0;
        tick();
        n_cmp++;
        if ({f_sel, f_v, f_m, f_e} !== {5'd4, 1'b0, 1'b0, 8'd1}) begin
            n_bad++;
            $display("FAIL idle_hold got %h want %h",
                     {f_sel, f_v, f_m, f_e}, {5'd4, 1'b0, 1'b0, 8'd1});
        end
        #2;
        clear = 1'b1;
        #1;
        n_cmp++;
        if ({f_sel, f_v, f_m, f_e} !== 15'h0) begin
            n_bad++;
            $display("FAIL async_clear got %h want 0", {f_sel, f_v, f_m, f_e});
        end
        clear = 1'b0;
        en = 1'b0;
    endtask

    task automatic test_lock_abort();
        pulse_clear();
        en = 1'b1;
        req = 24'h000080;
        tick();
        n_cmp++;
        if ({r_sel, r_v} !== {5'd7, 1'b1}) begin
            n_bad++;
            $display("FAIL abort_grant got %h want %h", {r_sel, r_v}, {5'd7, 1'b1});
        end
        lock = 1'b1;
        req = 24'h800001;
        #2;
        clear = 1'b1;
        #1;
        clear = 1'b0;
        tick();
        n_cmp++;
        if ({r_sel, r_v, r_m} !== {5'd0, 1'b1, 1'b1}) begin
            n_bad++;
            $display("FAIL abort_ptr0 got %h want %h",
                     {r_sel, r_v, r_m}, {5'd0, 1'b1, 1'b1});
        end
        lock = 1'b0;
        req = '0;
        en = 1'b0;
    endtask

    initial begin
        tick();
        test_reset();
        test_fixed();
        test_round_robin();
        test_lock();
        test_saturate();
        test_idle_clear();
        test_lock_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bus_grant_encoder.md
BUS_GRANT_ENCODER -- requirements
Module: bus_grant_encoder

Interface
REQ-001 Parameter N_SRC, default 24, number of bus-source request lines (2..32).
REQ-002 Parameter SEL_W, default 5, width of encoded select; SHALL satisfy 2**SEL_W >= N_SRC.
REQ-003 Parameter RR_MODE, default 0, 0 = fixed priority (index 0 highest), 1 = round-robin.
REQ-004 Parameter CNT_W, default 8, width of collision counter.
REQ-005 clock  in  1  single clock, all state updates on rising edge.
REQ-006 clear  in  1  asynchronous, active-high reset.
REQ-007 req  in  N_SRC  bus-source out-enable requests, bit i = source i.
REQ-008 en  in  1  arbitration enable; req sampled only when high.
REQ-009 lock  in  1  hold current grant for multi-cycle transfer.
REQ-010 clr_err  in  1  synchronous clear of collision counter.
REQ-011 sel  out  SEL_W  registered encoded index of granted source.
REQ-012 sel_valid  out  1  registered, high when sel names an active grant.
REQ-013 multi  out  1  registered, high when last arbitrated cycle saw two or more requests.
REQ-014 err_cnt  out  CNT_W  saturating count of collision cycles.

Function
REQ-015 Latency SHALL be one cycle: req sampled at edge k appears on sel/sel_valid after edge k.
REQ-016 Arbitration cycle: en=1 and NOT (lock=1 and sel_valid=1).
REQ-017 Fixed priority (RR_MODE=0): grant lowest-index set bit of req.
REQ-018 Round-robin (RR_MODE=1): search from index ptr upward, wrapping N_SRC-1 -> 0; grant first set bit.
REQ-019 ptr SHALL be internal, reset 0, updated to (granted index + 1) mod N_SRC on every arbitration cycle with a grant; unchanged otherwise.
REQ-020 Arbitration cycle with req nonzero: sel <= granted index, sel_valid <= 1.
REQ-021 Arbitration cycle with req == 0: sel holds previous value, sel_valid <= 0; sel SHALL never be X.
REQ-022 en=0: sel, sel_valid, multi, ptr hold; err_cnt changes only via clr_err.
REQ-023 lock=1 with sel_valid=1: sel, sel_valid, ptr hold regardless of req; multi <= 0; no collision counted.
REQ-024 lock=1 with sel_valid=0: treated as a normal arbitration cycle (lock takes effect once a grant exists).
REQ-025 multi <= 1 on arbitration cycle with popcount(req) >= 2, else multi <= 0.
REQ-026 err_cnt increments by 1 on each arbitration cycle with popcount(req) >= 2; saturates at 2**CNT_W-1, no wrap.
REQ-027 clr_err=1 sets err_cnt to 0 at next edge; wins over simultaneous increment.
REQ-028 Request bits above N_SRC-1 do not exist; sel SHALL only take values 0..N_SRC-1.
REQ-029 Implementation is a two-state grant FSM (IDLE: sel_valid=0; GRANTED: sel_valid=1) with transitions per REQ-020..REQ-024.

Reset
REQ-030 clear=1 SHALL asynchronously force sel=0, sel_valid=0, multi=0, err_cnt=0, ptr=0, FSM=IDLE.
REQ-031 clear asserted mid-lock SHALL abort the lock; first post-reset arbitration cycle uses ptr=0.
REQ-032 While clear=1, all inputs ignored; outputs hold reset values.

Verification
REQ-033 RR_MODE=0, en=1, req=0x000024 (bits 2,5) -> next cycle sel=2, sel_valid=1, multi=1, err_cnt=1.
REQ-034 RR_MODE=1, req=0x800001 held 3 cycles after reset -> sel=0, 23, 0 (wrap), err_cnt=3.
REQ-035 Grant sel=7, then lock=1 with req=0x000001 for 4 cycles -> sel stays 7, sel_valid=1, multi=0, err_cnt unchanged; lock=0 -> sel=0.
REQ-036 CNT_W=2, collisions for 5 consecutive cycles -> err_cnt 1,2,3,3,3; clr_err with collision same cycle -> err_cnt=0.
REQ-037 req=0 after grant sel=4 -> sel=4, sel_valid=0; clear pulsed between edges -> immediately sel=0, sel_valid=0, err_cnt=0.
